// File: rtl/osched_pkg.sv
// Shared constants, state encoding and slice helper for the two-channel output scheduler.
package osched_pkg;

   localparam int DATA_W   = 12;
   localparam int SLICE_W  = 2;
   localparam int NSLICE   = 6;
   localparam int MIN_SLOT = 8;
   localparam int CNT_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RDY   = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } osched_state_e;

   // Slice k of a sample, LSB-first.
   function automatic logic [SLICE_W-1:0] get_slice(input logic [DATA_W-1:0] d,
                                                    input logic [2:0]        k);
      logic [DATA_W-1:0] s;
      s = d >> (SLICE_W * int'(k));
      return s[SLICE_W-1:0];
   endfunction

endpackage

// File: rtl/output_scheduler_if.sv
// Sample-source handshake and output-terminal link bundle for output_scheduler.
interface output_scheduler_if;
   import osched_pkg::*;

   logic                en;
   logic                req0;
   logic [DATA_W-1:0]   x0;
   logic [DATA_W-1:0]   y0;
   logic                inv0;
   logic                ack0;
   logic                req1;
   logic [DATA_W-1:0]   x1;
   logic [DATA_W-1:0]   y1;
   logic                inv1;
   logic                ack1;
   logic                Rdy;
   logic [SLICE_W-1:0]  Xo;
   logic [SLICE_W-1:0]  Yo;
   logic                ISo;
   logic                gnt_id;
   logic                busy;

   modport slave (
      input  en, req0, x0, y0, inv0, req1, x1, y1, inv1,
      output ack0, ack1, Rdy, Xo, Yo, ISo, gnt_id, busy
   );

   modport master (
      output en, req0, x0, y0, inv0, req1, x1, y1, inv1,
      input  ack0, ack1, Rdy, Xo, Yo, ISo, gnt_id, busy
   );

endinterface

// File: rtl/osched_rr_arb.sv
// Two-way arbiter: round-robin by default, ch0 fixed priority when OSCHED_FIXED_PRIO_EN is defined.
module osched_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);

`ifdef OSCHED_FIXED_PRIO_EN

   always_comb begin
      gnt = 2'b00;
      if (req[0]) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
   end

`else

   // last_q = channel granted most recently; resets to 1 so ch0 wins first.
   logic last_q;
   logic last_d;

   always_comb begin
      gnt    = req;
      last_d = last_q;
      if (req == 2'b11) begin
         gnt = last_q ? 2'b01 : 2'b10;
      end
      if (adv && (gnt != 2'b00)) begin
         last_d = gnt[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

`endif

endmodule

// File: rtl/output_scheduler.sv
// Shares one 2-bit Rdy/X/Y/IS link between two sample sources; arbitration is in osched_rr_arb
// (OSCHED_FIXED_PRIO_EN selects fixed ch0 priority there).
//
// state | meaning
// IDLE  | arbitration cycle; grant and capture a sample if en and any req
// RDY   | Rdy pulse, ack to winner, ISo updated
// SHIFT | six X/Y slices LSB-first, slot counter 0..5
// HOLD  | idle padding out to SLOT_CYC, Xo=Yo=0
module output_scheduler
   import osched_pkg::*;
#(
   parameter int SLOT_CYC = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   output_scheduler_if.slave bus
);

   if ((SLOT_CYC < MIN_SLOT) || (SLOT_CYC > 255)) begin : g_bad_slot
      $error("output_scheduler: SLOT_CYC=%0d outside legal range 8..255", SLOT_CYC);
   end

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(NSLICE - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SLOT_CYC - 3);
   localparam bit               HOLD_EN    = (SLOT_CYC > MIN_SLOT);

   osched_state_e       state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   sx_q, sx_d;
   logic [DATA_W-1:0]   sy_q, sy_d;
   logic                rdy_q, rdy_d;
   logic [1:0]          ack_q, ack_d;
   logic [SLICE_W-1:0]  xo_q, xo_d;
   logic [SLICE_W-1:0]  yo_q, yo_d;
   logic                iso_q, iso_d;
   logic                gid_q, gid_d;
   logic                busy_q, busy_d;

   logic [1:0]          req;
   logic [1:0]          gnt;
   logic                adv;

   assign req = {bus.req1, bus.req0};
   assign adv = (state_q == IDLE) && bus.en && (req != 2'b00);

   osched_rr_arb u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .adv   (adv),
      .gnt   (gnt)
   );

   // Outputs are registered, so each state computes what the link shows in the next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      iso_d   = iso_q;
      gid_d   = gid_q;
      rdy_d   = 1'b0;
      ack_d   = 2'b00;
      xo_d    = '0;
      yo_d    = '0;
      unique case (state_q)
         IDLE: begin
            if (adv) begin
               state_d = RDY;
               rdy_d   = 1'b1;
               ack_d   = gnt;
               gid_d   = gnt[1];
               sx_d    = gnt[1] ? bus.x1   : bus.x0;
               sy_d    = gnt[1] ? bus.y1   : bus.y0;
               iso_d   = gnt[1] ? bus.inv1 : bus.inv0;
            end
         end
         RDY: begin
            state_d = SHIFT;
            cnt_d   = '0;
            xo_d    = get_slice(sx_q, 3'd0);
            yo_d    = get_slice(sy_q, 3'd0);
         end
         SHIFT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHIFT_LAST) begin
               state_d = HOLD_EN ? HOLD : IDLE;
            end else begin
               xo_d = get_slice(sx_q, cnt_q[2:0] + 3'd1);
               yo_d = get_slice(sy_q, cnt_q[2:0] + 3'd1);
            end
         end
         HOLD: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HOLD_LAST) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         rdy_q   <= 1'b0;
         ack_q   <= 2'b00;
         xo_q    <= '0;
         yo_q    <= '0;
         iso_q   <= 1'b0;
         gid_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         rdy_q   <= rdy_d;
         ack_q   <= ack_d;
         xo_q    <= xo_d;
         yo_q    <= yo_d;
         iso_q   <= iso_d;
         gid_q   <= gid_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.Rdy    = rdy_q;
   assign bus.ack0   = ack_q[0];
   assign bus.ack1   = ack_q[1];
   assign bus.Xo     = xo_q;
   assign bus.Yo     = yo_q;
   assign bus.ISo    = iso_q;
   assign bus.gnt_id = gid_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_output_scheduler.sv
// Bench for output_scheduler: SLOT_CYC=8 and SLOT_CYC=12 instances against a slot-timing reference model.
module tb_output_scheduler;

`ifdef OSCHED_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   output_scheduler_if bus8();
   output_scheduler_if bus12();

   output_scheduler #(.SLOT_CYC(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   output_scheduler #(.SLOT_CYC(12)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

   logic        en_v  [2];
   logic        req_v [2][2];
   logic [11:0] x_v   [2][2];
   logic [11:0] y_v   [2][2];
   logic        inv_v [2][2];

   logic        rdy_o [2];
   logic [1:0]  ack_o [2];
   logic [1:0]  xo_o  [2];
   logic [1:0]  yo_o  [2];
   logic        iso_o [2];
   logic        gid_o [2];
   logic        busy_o[2];

   assign bus8.en   = en_v[0];
   assign bus8.req0 = req_v[0][0];
   assign bus8.x0   = x_v[0][0];
   assign bus8.y0   = y_v[0][0];
   assign bus8.inv0 = inv_v[0][0];
   assign bus8.req1 = req_v[0][1];
   assign bus8.x1   = x_v[0][1];
   assign bus8.y1   = y_v[0][1];
   assign bus8.inv1 = inv_v[0][1];
   assign rdy_o[0]  = bus8.Rdy;
   assign ack_o[0]  = {bus8.ack1, bus8.ack0};
   assign xo_o[0]   = bus8.Xo;
   assign yo_o[0]   = bus8.Yo;
   assign iso_o[0]  = bus8.ISo;
   assign gid_o[0]  = bus8.gnt_id;
   assign busy_o[0] = bus8.busy;

   assign bus12.en   = en_v[1];
   assign bus12.req0 = req_v[1][0];
   assign bus12.x0   = x_v[1][0];
   assign bus12.y0   = y_v[1][0];
   assign bus12.inv0 = inv_v[1][0];
   assign bus12.req1 = req_v[1][1];
   assign bus12.x1   = x_v[1][1];
   assign bus12.y1   = y_v[1][1];
   assign bus12.inv1 = inv_v[1][1];
   assign rdy_o[1]   = bus12.Rdy;
   assign ack_o[1]   = {bus12.ack1, bus12.ack0};
   assign xo_o[1]    = bus12.Xo;
   assign yo_o[1]    = bus12.Yo;
   assign iso_o[1]   = bus12.ISo;
   assign gid_o[1]   = bus12.gnt_id;
   assign busy_o[1]  = bus12.busy;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
      end
   endtask

   function automatic int slot_of(input int d);
      return (d == 0) ? 8 : 12;
   endfunction

   // Reference model: a slot is busy for SLOT_CYC-1 cycles starting at its Rdy; the next
   // cycle is the arbitration cycle. Slices are read straight out of the granted sample.
   int          cyc      [2];
   int          last_rdy [2];
   logic        last_win [2];
   logic        iso_m    [2];
   logic        gid_m    [2];
   logic [11:0] mx       [2];
   logic [11:0] my       [2];
   logic        rst_p;
   logic        en_p  [2];
   logic        req_p [2][2];
   logic [11:0] x_p   [2][2];
   logic [11:0] y_p   [2][2];
   logic        inv_p [2][2];
   int          src_mode[2];   // 0 manual, 1 continuous, 2 random

   task automatic new_sample(input int d, input int c);
      x_v[d][c]   = 12'($urandom);
      y_v[d][c]   = 12'($urandom);
      inv_v[d][c] = 1'($urandom);
      req_v[d][c] = 1'b1;
   endtask

   task automatic cycle();
      logic        w;
      logic        e_rdy;
      logic [1:0]  e_ack;
      logic [1:0]  exo, eyo;
      logic [11:0] tx, ty;
      int          k;
      bit          idle_prev;
      rst_p = rst_n;
      for (int d = 0; d < 2; d++) begin
         en_p[d] = en_v[d];
         for (int c = 0; c < 2; c++) begin
            req_p[d][c] = req_v[d][c];
            x_p[d][c]   = x_v[d][c];
            y_p[d][c]   = y_v[d][c];
            inv_p[d][c] = inv_v[d][c];
         end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         cyc[d]++;
         e_rdy = 1'b0;
         e_ack = 2'b00;
         if (!rst_n) begin
            last_rdy[d] = -1000;
            last_win[d] = 1'b1;
            iso_m[d]    = 1'b0;
            gid_m[d]    = 1'b0;
         end else begin
            idle_prev = ((cyc[d] - 1 - last_rdy[d]) >= slot_of(d) - 1);
            if (rst_p && idle_prev && en_p[d] && (req_p[d][0] || req_p[d][1])) begin
               if (req_p[d][0] && req_p[d][1]) w = FIXED ? 1'b0 : !last_win[d];
               else w = req_p[d][1];
               e_rdy       = 1'b1;
               e_ack       = w ? 2'b10 : 2'b01;
               last_win[d] = w;
               last_rdy[d] = cyc[d];
               mx[d]       = x_p[d][w];
               my[d]       = y_p[d][w];
               iso_m[d]    = inv_p[d][w];
               gid_m[d]    = w;
            end
         end
         k   = cyc[d] - last_rdy[d] - 1;
         exo = 2'b00;
         eyo = 2'b00;
         if (rst_n && k >= 0 && k < 6) begin
            tx  = mx[d] >> (2 * k);
            ty  = my[d] >> (2 * k);
            exo = tx[1:0];
            eyo = ty[1:0];
         end
         chk("rdy",    d, 32'(rdy_o[d]),  32'(e_rdy));
         chk("ack",    d, 32'(ack_o[d]),  32'(e_ack));
         chk("xo",     d, 32'(xo_o[d]),   32'(exo));
         chk("yo",     d, 32'(yo_o[d]),   32'(eyo));
         chk("iso",    d, 32'(iso_o[d]),  32'(iso_m[d]));
         chk("gnt_id", d, 32'(gid_o[d]),  32'(gid_m[d]));
         chk("busy",   d, 32'(busy_o[d]),
             32'(rst_n && ((cyc[d] - last_rdy[d]) < slot_of(d) - 1)));
         if (src_mode[d] != 0) begin
            for (int c = 0; c < 2; c++) begin
               if (ack_o[d][c]) begin
                  if (src_mode[d] == 2 && $urandom_range(3) == 0) req_v[d][c] = 1'b0;
                  else new_sample(d, c);
               end else if (!req_v[d][c] && (src_mode[d] == 1 || $urandom_range(2) == 0)) begin
                  new_sample(d, c);
               end
            end
            if (src_mode[d] == 2 && $urandom_range(15) == 0) en_v[d] = !en_v[d];
         end
      end
   endtask

   task automatic wait_rdy(input int d, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         cycle();
         if (rdy_o[d]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      logic            ch;
      logic [11:0]     x;
      logic [11:0]     y;
      logic            inv;
      logic [5:0][1:0] xs;   // expected slice k at xs[k]
      logic [5:0][1:0] ys;
   } vec_t;

   vec_t tbl[4];

   initial begin
      bit   ok;
      int   cnt;
      int   last_t [2];
      logic prev_g [2];
      bit   seen   [2];

      tbl[0] = '{ch:1'b0, x:12'hABC, y:12'h123, inv:1'b1,
                 xs:{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0},
                 ys:{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3}};
      tbl[1] = '{ch:1'b1, x:12'h5A3, y:12'hFFF, inv:1'b0,
                 xs:{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3},
                 ys:{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}};
      tbl[2] = '{ch:1'b0, x:12'h000, y:12'h801, inv:1'b1,
                 xs:{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                 ys:{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1}};
      tbl[3] = '{ch:1'b1, x:12'hFFF, y:12'h000, inv:1'b1,
                 xs:{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3},
                 ys:{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         en_v[d]     = 1'b1;
         src_mode[d] = 0;
         cyc[d]      = 0;
         last_rdy[d] = -1000;
         last_win[d] = 1'b1;
         iso_m[d]    = 1'b0;
         gid_m[d]    = 1'b0;
         mx[d]       = '0;
         my[d]       = '0;
         for (int c = 0; c < 2; c++) begin
            req_v[d][c] = 1'b0;
            x_v[d][c]   = '0;
            y_v[d][c]   = '0;
            inv_v[d][c] = 1'b0;
         end
      end
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();

      // Single-channel vectors on the SLOT_CYC=8 instance
      for (int i = 0; i < 4; i++) begin
         req_v[0][tbl[i].ch] = 1'b1;
         x_v[0][tbl[i].ch]   = tbl[i].x;
         y_v[0][tbl[i].ch]   = tbl[i].y;
         inv_v[0][tbl[i].ch] = tbl[i].inv;
         wait_rdy(0, 20, ok);
         chk("tbl_rdy_seen", 0, 32'(ok), 32'd1);
         chk("tbl_ack", 0, 32'(ack_o[0]), tbl[i].ch ? 32'd2 : 32'd1);
         chk("tbl_gnt", 0, 32'(gid_o[0]), 32'(tbl[i].ch));
         chk("tbl_iso", 0, 32'(iso_o[0]), 32'(tbl[i].inv));
         req_v[0][tbl[i].ch] = 1'b0;
         for (int k = 0; k < 6; k++) begin
            cycle();
            chk("tbl_xo", 0, 32'(xo_o[0]), 32'(tbl[i].xs[k]));
            chk("tbl_yo", 0, 32'(yo_o[0]), 32'(tbl[i].ys[k]));
         end
         cycle();
         chk("tbl_iso_vld", 0, 32'(iso_o[0]), 32'(tbl[i].inv));
         chk("tbl_xo_idle", 0, 32'(xo_o[0]), 32'd0);
      end

      // Both channels requesting continuously: period and alternation
      src_mode[0] = 1;
      src_mode[1] = 1;
      seen[0] = 1'b0;
      seen[1] = 1'b0;
      for (int i = 0; i < 80; i++) begin
         cycle();
         for (int d = 0; d < 2; d++) begin
            if (rdy_o[d]) begin
               if (seen[d]) begin
                  chk("rdy_period", d, 32'(cyc[d] - last_t[d]), 32'(slot_of(d)));
                  chk("gnt_order", d, 32'(gid_o[d]), FIXED ? 32'd0 : 32'(!prev_g[d]));
               end
               seen[d]   = 1'b1;
               last_t[d] = cyc[d];
               prev_g[d] = gid_o[d];
            end
         end
      end

      // en dropped in SHIFT cycle 2
      wait_rdy(0, 20, ok);
      chk("en_rdy_seen", 0, 32'(ok), 32'd1);
      repeat (3) cycle();
      en_v[0] = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (rdy_o[0]) cnt++;
      end
      chk("en_off_no_rdy", 0, 32'(cnt), 32'd0);
      en_v[0] = 1'b1;
      wait_rdy(0, 2, ok);
      chk("en_on_rdy", 0, 32'(ok), 32'd1);

      // Async reset in SHIFT cycle 3
      wait_rdy(0, 20, ok);
      chk("rst_rdy_seen", 0, 32'(ok), 32'd1);
      repeat (4) cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_rdy",  0, 32'(rdy_o[0]),  32'd0);
      chk("rst_async_ack",  0, 32'(ack_o[0]),  32'd0);
      chk("rst_async_xy",   0, 32'({xo_o[0], yo_o[0]}), 32'd0);
      chk("rst_async_iso",  0, 32'(iso_o[0]),  32'd0);
      chk("rst_async_gnt",  0, 32'(gid_o[0]),  32'd0);
      chk("rst_async_busy", 0, 32'(busy_o[0]), 32'd0);
      cycle();
      rst_n = 1'b1;
      req_v[0][0] = 1'b1;
      req_v[0][1] = 1'b1;
      wait_rdy(0, 3, ok);
      chk("rst_release_rdy", 0, 32'(ok), 32'd1);
      chk("rst_first_gnt", 0, 32'(gid_o[0]), 32'd0);
      wait_rdy(0, 20, ok);
      chk("rst_second_gnt", 0, 32'(gid_o[0]), FIXED ? 32'd0 : 32'd1);

      // Randomized traffic and en toggling on both instances
      src_mode[0] = 2;
      src_mode[1] = 2;
      repeat (3000) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
